// File: rtl/dif_data_arranger.sv
// dif_data_arranger
// Output reorder buffer for the 64-point radix-2 DIF FFT pipeline.
// Bit-reversed samples from PE0 are written into an 8-bank x 8-word
// transpose memory and read back in natural order. The FFT controller
// drives every write/read target through the da_* control words, so
// this block holds no sequencing state of its own: it is a plain
// one-write/one-read memory with a registered output and a sticky
// target-mismatch flag.
//
// Control word encoding (write and read alike):
//   bit 3 = 1 -> port idle this cycle
//   bit 3 = 0 -> bank = [2:0] (bank words) / word = [2:0] (address words)
// Address bit 3 is never used. Code 8 on all four words is a full halt.
//
// Same-cell read and write in one cycle is the normal in-place transpose
// case: the read returns the old word, the new word is visible from the
// following cycle.

module dif_data_arranger #(
    parameter int DATA_WIDTH = 16,
    parameter int BANKS      = 8,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] din_re,
    input  logic signed [DATA_WIDTH-1:0] din_im,
    input  logic        [3:0]            da_wen_ctrl,
    input  logic        [3:0]            da_waddr_ctrl,
    input  logic        [3:0]            da_ren_ctrl,
    input  logic        [3:0]            da_raddr_ctrl,
    output logic signed [DATA_WIDTH-1:0] dout_re,
    output logic signed [DATA_WIDTH-1:0] dout_im,
    output logic                         da_err
);

    localparam int BW = $clog2(BANKS);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = 2 * DATA_WIDTH;

    // Storage: one complex word {re, im} per cell, deliberately not reset.
    logic [WW-1:0] mem [BANKS][DEPTH];

    // Decoded control fields.
    logic          wr_en;
    logic          rd_en;
    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] rd_bank;
    logic [AW-1:0] rd_addr;
    logic          target_mismatch;
    logic [WW-1:0] rd_word;

    // Address bit 3 of both address words carries no meaning here.
    logic unused_addr_msb;
    assign unused_addr_msb = da_waddr_ctrl[3] ^ da_raddr_ctrl[3];

    assign wr_en   = ~da_wen_ctrl[3];
    assign rd_en   = ~da_ren_ctrl[3];
    assign wr_bank = da_wen_ctrl[BW-1:0];
    assign wr_addr = da_waddr_ctrl[AW-1:0];
    assign rd_bank = da_ren_ctrl[BW-1:0];
    assign rd_addr = da_raddr_ctrl[AW-1:0];

    // A cycle with both ports active must target one cell; anything else
    // means the controller sequence is broken.
    assign target_mismatch = wr_en && rd_en &&
                             ({wr_bank, wr_addr} != {rd_bank, rd_addr});

    // Asynchronous array read; the output register below samples it at
    // the same edge the write lands, which gives read-before-write.
    assign rd_word = mem[rd_bank][rd_addr];

    // Memory write port; reset does not gate it because the written
    // contents are never read before the controller refills the frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= {din_re, din_im};
        end
    end

    // Registered read data: load on a read cycle, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_re <= '0;
            dout_im <= '0;
        end else if (rd_en) begin
            dout_re <= rd_word[WW-1:DATA_WIDTH];
            dout_im <= rd_word[DATA_WIDTH-1:0];
        end
    end

    // Sticky mismatch flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            da_err <= 1'b0;
        end else if (target_mismatch) begin
            da_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dif_data_arranger.sv
// Testbench for dif_data_arranger: directed scenarios plus a randomized
// run, all checked against a flat 64-entry array model of the buffer.

module tb_dif_data_arranger;

  logic               clk;
  logic               rst;
  logic signed [15:0] din_re;
  logic signed [15:0] din_im;
  logic        [3:0]  da_wen_ctrl;
  logic        [3:0]  da_waddr_ctrl;
  logic        [3:0]  da_ren_ctrl;
  logic        [3:0]  da_raddr_ctrl;
  logic signed [15:0] dout_re;
  logic signed [15:0] dout_im;
  logic               da_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: cell index = bank*8 + addr.
  logic [31:0] ref_mem   [64];
  bit          ref_valid [64];
  logic [31:0] ref_dout;
  bit          ref_known;
  logic        ref_err;

  // Scoreboard of expected dout words for the transpose scenario.
  logic [31:0] exp_q[$];

  dif_data_arranger #(
    .DATA_WIDTH(16),
    .BANKS(8),
    .DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din_re(din_re),
    .din_im(din_im),
    .da_wen_ctrl(da_wen_ctrl),
    .da_waddr_ctrl(da_waddr_ctrl),
    .da_ren_ctrl(da_ren_ctrl),
    .da_raddr_ctrl(da_raddr_ctrl),
    .dout_re(dout_re),
    .dout_im(dout_im),
    .da_err(da_err)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b0;
    din_re = '0;
    din_im = '0;
    da_wen_ctrl = 4'h8;
    da_waddr_ctrl = 4'h8;
    da_ren_ctrl = 4'h8;
    da_raddr_ctrl = 4'h8;
    for (int i = 0; i < 64; i++) begin
      ref_valid[i] = 1'b0;
      ref_mem[i] = '0;
    end
    ref_dout = '0;
    ref_known = 1'b0;
    ref_err = 1'b0;
  end

  // Driver: apply one cycle of inputs, advance the model, settle #1
  // after the edge so outputs are sampled away from it.
  task automatic cycle(input logic r, input logic [3:0] we, input logic [3:0] wa,
                       input logic [3:0] rd, input logic [3:0] ra,
                       input logic [15:0] dre, input logic [15:0] dim);
    int wi;
    int ri;
    rst = r;
    da_wen_ctrl = we;
    da_waddr_ctrl = wa;
    da_ren_ctrl = rd;
    da_raddr_ctrl = ra;
    din_re = dre;
    din_im = dim;
    @(posedge clk);
    wi = int'(we[2:0]) * 8 + int'(wa[2:0]);
    ri = int'(rd[2:0]) * 8 + int'(ra[2:0]);
    if (r) begin
      ref_dout = '0;
      ref_known = 1'b1;
      ref_err = 1'b0;
      if (!we[3]) ref_valid[wi] = 1'b0;
    end else begin
      if (!rd[3]) begin
        ref_dout = ref_mem[ri];
        ref_known = ref_valid[ri];
      end
      if (!we[3]) begin
        ref_mem[wi] = {dre, dim};
        ref_valid[wi] = 1'b1;
      end
      if (!we[3] && !rd[3] && wi != ri) ref_err = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 4'h8, 4'h8, 4'h8, 4'h8, 16'($urandom), 16'($urandom));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            16'($urandom), 16'($urandom));
      tests_run++;
      if ({dout_re, dout_im} !== 32'h0 || da_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_cycle%0d: dout=%h err=%b expected dout=0 err=0",
                 i, {dout_re, dout_im}, da_err);
      end
    end
    idle();
    tests_run++;
    if ({dout_re, dout_im} !== 32'h0 || da_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_after: dout=%h err=%b expected dout=0 err=0",
               {dout_re, dout_im}, da_err);
    end
  endtask

  task automatic test_single_write_read();
    cycle(1'b0, 4'h3, 4'h5, 4'h8, 4'h8, 16'h1234, 16'h5678);
    tests_run++;
    if ({dout_re, dout_im} !== 32'h0) begin
      tests_failed++;
      $display("FAIL single_hold: dout=%h expected 00000000", {dout_re, dout_im});
    end
    cycle(1'b0, 4'h8, 4'h8, 4'h3, 4'hD, 16'h0, 16'h0);
    tests_run++;
    if (dout_re !== 16'h1234 || dout_im !== 16'h5678) begin
      tests_failed++;
      $display("FAIL single_read: dout=%h/%h expected 1234/5678", dout_re, dout_im);
    end
  endtask

  task automatic test_read_before_write();
    logic [15:0] a_re;
    logic [15:0] a_im;
    logic [15:0] b_re;
    logic [15:0] b_im;
    a_re = 16'($urandom);
    a_im = 16'($urandom);
    b_re = ~a_re;
    b_im = a_im + 16'd1;
    cycle(1'b0, 4'h2, 4'h6, 4'h8, 4'h8, a_re, a_im);
    cycle(1'b0, 4'h2, 4'h6, 4'h2, 4'h6, b_re, b_im);
    tests_run++;
    if (dout_re !== a_re || dout_im !== a_im || da_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rbw_old: dout=%h/%h err=%b expected %h/%h err=0",
               dout_re, dout_im, da_err, a_re, a_im);
    end
    cycle(1'b0, 4'h8, 4'h8, 4'h2, 4'h6, 16'h0, 16'h0);
    tests_run++;
    if (dout_re !== b_re || dout_im !== b_im || da_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rbw_new: dout=%h/%h err=%b expected %h/%h err=0",
               dout_re, dout_im, da_err, b_re, b_im);
    end
  endtask

  task automatic test_halt();
    logic [31:0] held;
    cycle(1'b0, 4'h4, 4'h1, 4'h8, 4'h8, 16'hCAFE, 16'hBEEF);
    cycle(1'b0, 4'h8, 4'h8, 4'h4, 4'h1, 16'h0, 16'h0);
    held = {dout_re, dout_im};
    tests_run++;
    if (held !== 32'hCAFEBEEF) begin
      tests_failed++;
      $display("FAIL halt_setup: dout=%h expected cafebeef", held);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'h8, 4'h8, 4'h8, 4'h8, 16'($urandom), 16'($urandom));
      tests_run++;
      if ({dout_re, dout_im} !== 32'hCAFEBEEF) begin
        tests_failed++;
        $display("FAIL halt_hold%0d: dout=%h expected cafebeef", i, {dout_re, dout_im});
      end
    end
    cycle(1'b0, 4'h8, 4'h8, 4'h3, 4'h5, 16'h0, 16'h0);
    tests_run++;
    if ({dout_re, dout_im} !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL halt_mem_b3a5: dout=%h expected 12345678", {dout_re, dout_im});
    end
    cycle(1'b0, 4'h8, 4'h8, 4'h4, 4'h1, 16'h0, 16'h0);
    tests_run++;
    if ({dout_re, dout_im} !== 32'hCAFEBEEF) begin
      tests_failed++;
      $display("FAIL halt_mem_b4a1: dout=%h expected cafebeef", {dout_re, dout_im});
    end
  endtask

  task automatic test_mismatch();
    cycle(1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 16'h1111, 16'h2222);
    tests_run++;
    if (da_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL mismatch_set: err=%b expected 1", da_err);
    end
    for (int i = 0; i < 10; i++) begin
      idle();
      tests_run++;
      if (da_err !== 1'b1) begin
        tests_failed++;
        $display("FAIL mismatch_sticky%0d: err=%b expected 1", i, da_err);
      end
    end
    cycle(1'b1, 4'h8, 4'h8, 4'h8, 4'h8, 16'h0, 16'h0);
    tests_run++;
    if (da_err !== 1'b0 || {dout_re, dout_im} !== 32'h0) begin
      tests_failed++;
      $display("FAIL mismatch_clear: err=%b dout=%h expected err=0 dout=0",
               da_err, {dout_re, dout_im});
    end
    cycle(1'b0, 4'h5, 4'h2, 4'h8, 4'h8, 16'h0, 16'h0);
    cycle(1'b0, 4'h8, 4'h8, 4'h6, 4'h7, 16'h0, 16'h0);
    tests_run++;
    if (da_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mismatch_single_port: err=%b expected 0", da_err);
    end
  endtask

  // Frame 1 written in bit-reversed layout, then read in natural order
  // while frame 2 overwrites the same cells, then frame 2 read out with
  // the swapped addressing while frame 3 overwrites.
  task automatic test_transpose();
    logic [5:0]  i6;
    logic [15:0] v;
    logic [31:0] exp_w;
    for (int i = 0; i < 64; i++) begin
      i6 = 6'(i);
      v = 16'(i);
      cycle(1'b0, {1'b0, i6[5:3]}, {1'b0, i6[2:0]}, 4'h8, 4'h8, v, ~v);
    end
    for (int j = 0; j < 64; j++) begin
      i6 = 6'(j);
      v = 16'(8 * int'(i6[2:0]) + int'(i6[5:3]));
      exp_q.push_back({v, ~v});
    end
    for (int j = 0; j < 64; j++) begin
      i6 = 6'(j);
      v = 16'(64 + j);
      cycle(1'b0, {1'b0, i6[2:0]}, {1'b0, i6[5:3]}, {1'b0, i6[2:0]}, {1'b0, i6[5:3]},
            v, ~v);
      exp_w = exp_q.pop_front();
      tests_run++;
      if ({dout_re, dout_im} !== exp_w || da_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL transpose_f1_j%0d: dout=%h err=%b expected %h err=0",
                 j, {dout_re, dout_im}, da_err, exp_w);
      end
    end
    for (int k = 0; k < 64; k++) begin
      i6 = 6'(k);
      v = 16'(64 + 8 * int'(i6[2:0]) + int'(i6[5:3]));
      exp_q.push_back({v, ~v});
    end
    for (int k = 0; k < 64; k++) begin
      i6 = 6'(k);
      v = 16'(128 + k);
      cycle(1'b0, {1'b0, i6[5:3]}, {1'b0, i6[2:0]}, {1'b0, i6[5:3]}, {1'b0, i6[2:0]},
            v, ~v);
      exp_w = exp_q.pop_front();
      tests_run++;
      if ({dout_re, dout_im} !== exp_w || da_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL transpose_f2_k%0d: dout=%h err=%b expected %h err=0",
                 k, {dout_re, dout_im}, da_err, exp_w);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] we;
    logic [3:0] wa;
    logic [3:0] rd;
    logic [3:0] ra;
    logic       r;
    for (int n = 0; n < 400; n++) begin
      we = 4'($urandom);
      wa = 4'($urandom);
      we[3] = ($urandom_range(0, 3) == 0);
      rd = 4'($urandom);
      ra = 4'($urandom);
      rd[3] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        rd[2:0] = we[2:0];
        ra = wa;
      end
      r = ($urandom_range(0, 49) == 0);
      cycle(r, we, wa, rd, ra, 16'($urandom), 16'($urandom));
      if (ref_known) begin
        tests_run++;
        if ({dout_re, dout_im} !== ref_dout) begin
          tests_failed++;
          $display("FAIL random_dout_n%0d: dout=%h expected %h",
                   n, {dout_re, dout_im}, ref_dout);
        end
      end
      tests_run++;
      if (da_err !== ref_err) begin
        tests_failed++;
        $display("FAIL random_err_n%0d: err=%b expected %b", n, da_err, ref_err);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_write_read();
    test_read_before_write();
    test_halt();
    test_mismatch();
    test_transpose();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
